// File: rtl/data_memory_responder_pkg.sv
// data_mem_pkg: shared FSM state type, default address width and load-extension helper
package data_mem_pkg;
  localparam int ADDR_WIDTH_DEFAULT = 9;
  typedef enum logic [1:0] {IDLE, READ, RESP} stateT;
  // Widens a byte or halfword to 32 bits, replicating its top bit only for signed loads.
  function automatic logic [31:0] extend_load(input logic [15:0] data16, input logic half, input logic isSigned);
    logic fill;
    fill = isSigned & (half ? data16[15] : data16[7]);
    return half ? {{16{fill}}, data16} : {{24{fill}}, data16[7:0]};
  endfunction
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response handshake bundle between a bus master and the data-memory responder
//   req_valid/req_ready  request handshake
//   req_write, req_half, req_signed, req_addr, req_wdata  request payload
//   rsp_valid/rsp_ready  response handshake, rsp_rdata  extended load data (0 for store acks)
interface data_memory_responder_if import data_mem_pkg::*; #(parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic req_half;
  logic req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [15:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_rdata;
  modport master (
    output req_valid, req_write, req_half, req_signed, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input req_valid, req_write, req_half, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/data_memory_responder_byte_bank.sv
// byte_bank: single-port 8-bit RAM, synchronous write and registered synchronous read
//   clk  clock, we  write enable, addr  BANK_AW-bit index, wdata  write byte, rdata  registered read byte
module byte_bank #(parameter int BANK_AW = 8) (
  input  logic               clk,
  input  logic               we,
  input  logic [BANK_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);
  logic [7:0] mem [2**BANK_AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: byte/halfword load-store responder over even and odd byte banks
//   clk    clock, reset  synchronous active-high reset
//   bus    slave side of data_memory_responder_if (request and response handshakes)
module data_memory_responder import data_mem_pkg::*; #(parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT) (
  input logic clk,
  input logic reset,
  data_memory_responder_if.slave bus
);
  localparam int BANK_AW = ADDR_WIDTH - 1;
  stateT state, nextState;
  logic accept, storeAcc, lsb;
  logic lsbQ, halfQ, signedQ;
  logic [BANK_AW-1:0] idx, evenAddr;
  logic evenWe, oddWe;
  logic [7:0] evenWdata, oddWdata, evenQ, oddQ, loByte, hiByte;
  logic [31:0] rdataQ;
  assign lsb = bus.req_addr[0];
  assign idx = bus.req_addr[ADDR_WIDTH-1:1];
  assign accept = state == IDLE && bus.req_valid;
  // Reset must win over a same-edge store, so it gates the bank write enables.
  assign storeAcc = accept && bus.req_write && !reset;
  // An odd start address pairs odd[idx] with the next even byte; the add wraps at the top of the bank.
  assign evenAddr = idx + BANK_AW'(lsb);
  assign evenWe = storeAcc && (bus.req_half || !lsb);
  assign oddWe = storeAcc && (bus.req_half || lsb);
  assign evenWdata = (bus.req_half && lsb) ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
  assign oddWdata = (bus.req_half && !lsb) ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
  byte_bank #(.BANK_AW(BANK_AW)) uEven (.clk(clk), .we(evenWe), .addr(evenAddr), .wdata(evenWdata), .rdata(evenQ));
  byte_bank #(.BANK_AW(BANK_AW)) uOdd (.clk(clk), .we(oddWe), .addr(idx), .wdata(oddWdata), .rdata(oddQ));
  assign loByte = lsbQ ? oddQ : evenQ;
  assign hiByte = lsbQ ? evenQ : oddQ;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state;
    if (accept) nextState = bus.req_write ? RESP : READ;
    else if (state == READ) nextState = RESP;
    else if (state == RESP && bus.rsp_ready) nextState = IDLE;
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    bus.rsp_rdata = rdataQ;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lsbQ <= 1'b0;
      halfQ <= 1'b0;
      signedQ <= 1'b0;
      rdataQ <= '0;
    end else begin
      if (accept) begin
        lsbQ <= lsb;
        halfQ <= bus.req_half;
        signedQ <= bus.req_signed;
        if (bus.req_write) rdataQ <= '0;
      end
      if (state == READ) rdataQ <= extend_load({hiByte, loByte}, halfQ, signedQ);
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard-based self-checking bench for data_memory_responder
module tb_data_memory_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  data_memory_responder_if #(.ADDR_WIDTH(9)) bus();
  data_memory_responder #(.ADDR_WIDTH(9)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAccept = 0;
  logic [31:0] expQ[$];
  logic [7:0] model [512];
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] modelLoad(input logic h, input logic s, input logic [8:0] a);
    logic [8:0] a1;
    logic [7:0] lo, hi;
    a1 = a + 9'd1;
    lo = model[a];
    hi = model[a1];
    if (h) return s ? {{16{hi[7]}}, hi, lo} : {16'h0000, hi, lo};
    return s ? {{24{lo[7]}}, lo} : {24'h000000, lo};
  endfunction

  task automatic transact(input logic w, input logic h, input logic s, input logic [8:0] a, input logic [15:0] wd,
                          output logic [31:0] rd, output int lat, output logic rdy);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_half = h;
    bus.req_signed = s;
    bus.req_addr = a;
    bus.req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr %0d: req_ready got 0, expected 1", a);
    end
    @(posedge clk);
    #1;
    lastAccept = cyc;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout addr %0d: rsp_valid got 0, expected 1", a);
    end
    rd = bus.rsp_rdata;
    rdy = bus.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic doStore(input logic h, input logic [8:0] a, input logic [15:0] wd,
                         output logic [31:0] rd, output int lat, output logic rdy);
    logic [8:0] a1;
    a1 = a + 9'd1;
    model[a] = wd[7:0];
    if (h) model[a1] = wd[15:8];
    expQ.push_back(32'h0);
    transact(1'b1, h, 1'b0, a, wd, rd, lat, rdy);
  endtask

  task automatic doLoad(input logic h, input logic s, input logic [8:0] a,
                        output logic [31:0] rd, output int lat, output logic rdy);
    expQ.push_back(modelLoad(h, s, a));
    transact(1'b0, h, s, a, 16'h0, rd, lat, rdy);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_half = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b expected 1", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b expected 0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h expected 0", bus.rsp_rdata); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_aligned_half;
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    logic [8:0] addrs [2] = '{9'd4, 9'd5};
    doStore(1'b1, 9'd4, 16'h8001, rd, lat, rdy);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL store_ack got %h expected %h", rd, exp); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL store_latency got %0d expected 1", lat); end
    doLoad(1'b1, 1'b1, 9'd4, rd, lat, rdy);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL aligned_signed_load got %h expected %h", rd, exp); end
    checks++;
    if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL aligned_signed_const got %h expected ffff8001", rd); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d expected 2", lat); end
    foreach (addrs[i]) begin
      doLoad(1'b0, 1'b0, addrs[i], rd, lat, rdy);
      exp = expQ.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL aligned_byte addr %0d got %h expected %h", addrs[i], rd, exp); end
    end
  endtask

  task automatic test_misaligned_half;
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    logic [8:0] addrs [4] = '{9'd6, 9'd7, 9'd8, 9'd9};
    doStore(1'b0, 9'd6, 16'h0011, rd, lat, rdy);
    void'(expQ.pop_front());
    doStore(1'b0, 9'd9, 16'h0022, rd, lat, rdy);
    void'(expQ.pop_front());
    doStore(1'b1, 9'd7, 16'hBEEF, rd, lat, rdy);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL misaligned_store_ack got %h expected %h", rd, exp); end
    doLoad(1'b1, 1'b0, 9'd7, rd, lat, rdy);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL misaligned_load got %h expected %h", rd, exp); end
    checks++;
    if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL misaligned_const got %h expected 0000beef", rd); end
    foreach (addrs[i]) begin
      doLoad(1'b0, 1'b0, addrs[i], rd, lat, rdy);
      exp = expQ.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL misaligned_byte addr %0d got %h expected %h", addrs[i], rd, exp); end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    logic [8:0] addrs [3] = '{9'd0, 9'd511, 9'd1};
    doStore(1'b0, 9'd1, 16'h005A, rd, lat, rdy);
    void'(expQ.pop_front());
    doStore(1'b1, 9'd511, 16'h1234, rd, lat, rdy);
    void'(expQ.pop_front());
    foreach (addrs[i]) begin
      doLoad(1'b0, 1'b0, addrs[i], rd, lat, rdy);
      exp = expQ.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL wrap_byte addr %0d got %h expected %h", addrs[i], rd, exp); end
    end
    doLoad(1'b1, 1'b0, 9'd511, rd, lat, rdy);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL wrap_half got %h expected %h", rd, exp); end
  endtask

  task automatic test_byte_loads;
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    logic sgn [2] = '{1'b1, 1'b0};
    doStore(1'b0, 9'd9, 16'hFF9C, rd, lat, rdy);
    void'(expQ.pop_front());
    foreach (sgn[i]) begin
      doLoad(1'b0, sgn[i], 9'd9, rd, lat, rdy);
      exp = expQ.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL byte_load signed=%b got %h expected %h", sgn[i], rd, exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, exp;
    int lat, prev;
    logic rdy;
    for (int i = 0; i < 3; i++) begin
      doStore(1'b0, 9'(20 + i), 16'(8'hC0 + i), rd, lat, rdy);
      exp = expQ.pop_front();
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_store_ready_in_resp got %b expected 0", rdy); end
      if (i > 0) begin
        checks++;
        if (lastAccept - prev !== 2) begin errors++; $display("FAIL store_throughput got %0d expected 2", lastAccept - prev); end
      end
      prev = lastAccept;
    end
    for (int i = 0; i < 3; i++) begin
      doLoad(1'b0, 1'b0, 9'(20 + i), rd, lat, rdy);
      exp = expQ.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL b2b_load addr %0d got %h expected %h", 20 + i, rd, exp); end
      if (i > 0) begin
        checks++;
        if (lastAccept - prev !== 3) begin errors++; $display("FAIL load_throughput got %0d expected 3", lastAccept - prev); end
      end
      prev = lastAccept;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    doStore(1'b1, 9'd30, 16'h4321, rd, lat, rdy);
    void'(expQ.pop_front());
    bus.rsp_ready = 1'b0;
    doLoad(1'b1, 1'b0, 9'd30, rd, lat, rdy);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL bp_load got %h expected %h", rd, exp); end
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_half = 1'b1;
      bus.req_addr = 9'd30;
      bus.req_wdata = 16'hFFFF;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h ready=%b expected 1 %h 0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, exp);
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ready=%b valid=%b expected 1 0", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    doLoad(1'b1, 1'b0, 9'd30, rd, lat, rdy);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL bp_ignored_store got %h expected %h", rd, exp); end
  endtask

  task automatic test_reset_priority;
    logic [31:0] rd, exp;
    int lat;
    logic rdy;
    doStore(1'b0, 9'd2, 16'h0055, rd, lat, rdy);
    void'(expQ.pop_front());
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_half = 1'b0;
    bus.req_addr = 9'd2;
    bus.req_wdata = 16'h00AA;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_store_state got valid=%b ready=%b expected 0 1", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1;
    doLoad(1'b0, 1'b0, 9'd2, rd, lat, rdy);
    exp = expQ.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL rst_no_write got %h expected %h", rd, exp); end
    bus.rsp_ready = 1'b0;
    transact(1'b0, 1'b0, 1'b0, 9'd2, 16'h0, rd, lat, rdy);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_discard got valid=%b ready=%b expected 0 1", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [31:0] rd, exp;
    int lat;
    logic rdy, h, w, s;
    logic [8:0] a;
    for (int i = 0; i < 16; i++) begin
      doStore(1'b1, 9'(100 + 2 * i), 16'($urandom), rd, lat, rdy);
      void'(expQ.pop_front());
    end
    for (int i = 0; i < 40; i++) begin
      h = 1'($urandom);
      w = 1'($urandom);
      s = 1'($urandom);
      a = 9'($urandom_range(100, 130));
      if (w) doStore(h, a, 16'($urandom), rd, lat, rdy);
      else doLoad(h, s, a, rd, lat, rdy);
      exp = expQ.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL random op %0d w=%b h=%b s=%b addr %0d got %h expected %h", i, w, h, s, a, rd, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_aligned_half();
    test_misaligned_half();
    test_wrap();
    test_byte_loads();
    test_back_to_back();
    test_backpressure();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
